// File: rtl/mem_resp_model_if.sv
// Request/response bundle between a request generator and mem_resp_model.
// The master drives the request side; the slave (the model) drives the response side.
interface mem_resp_model_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        Err;
    logic [15:0] ReqCount;
    logic [15:0] HitCount;

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Done, Stall, CacheHit, Err, ReqCount, HitCount
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Done, Stall, CacheHit, Err, ReqCount, HitCount
    );
endinterface

// File: rtl/mem_resp_model.sv
// Behavioural cache-plus-memory responder: direct-mapped tag array for hit/miss
// timing, flat zero-initialised word memory for exact data.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for Rd^Wr; accepts, allocates and updates memory
// S_MISS_WAIT | miss in flight; r_cnt counts down to the response
// S_RESP      | Done/CacheHit/DataOut presented for one cycle
module mem_resp_model #(
    parameter int MISS_LAT = 8,
    parameter int TAG_W    = 5,
    parameter int IDX_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_resp_model_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MISS_WAIT = 2'd1,
        S_RESP      = 2'd2
    } state_t;

    localparam int             LINES    = 1 << IDX_W;
    localparam int             CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MISS_LAT - 2);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_rd;
    logic [15:0]        r_rdata;
    logic [15:0]        r_dout;
    logic               r_done;
    logic               r_stall;
    logic               r_cache_hit;
    logic               r_err;
    logic [15:0]        r_req_cnt;
    logic [15:0]        r_hit_cnt;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag [0:LINES-1];

    // Memory contents model the backing store: zero at power-up, untouched by rst_n.
    logic [15:0]        r_mem [0:32767] = '{default: 16'h0000};

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag_in;
    logic               w_hit;
    logic               w_accept;
    logic [15:0]        w_mem_q;
    logic               w_unused_addr0;

    assign w_idx          = bus.Addr[3 +: IDX_W];
    assign w_tag_in       = bus.Addr[11 +: TAG_W];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag_in);
    assign w_accept       = (r_state == S_IDLE) && (bus.Rd ^ bus.Wr);
    assign w_mem_q        = r_mem[bus.Addr[15:1]];
    assign w_unused_addr0 = bus.Addr[0];

    // Storage without reset: word memory, tags and the pending read word.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (bus.Wr) begin
                r_mem[bus.Addr[15:1]] <= bus.DataIn;
            end
            r_tag[w_idx] <= w_tag_in;
            r_rdata      <= w_mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_rd     <= 1'b0;
            r_dout      <= '0;
            r_done      <= 1'b0;
            r_stall     <= 1'b0;
            r_cache_hit <= 1'b0;
            r_err       <= 1'b0;
            r_req_cnt   <= '0;
            r_hit_cnt   <= '0;
            r_valid     <= '0;
        end else begin
            r_done      <= 1'b0;
            r_cache_hit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Rd && bus.Wr) begin
                        r_err <= 1'b1;
                    end else if (w_accept) begin
                        r_valid[w_idx] <= 1'b1;
                        r_req_cnt      <= r_req_cnt + 16'd1;
                        r_is_rd        <= bus.Rd;
                        r_stall        <= 1'b1;
                        if (w_hit) begin
                            // Hit responds straight from memory in the next cycle.
                            r_state     <= S_RESP;
                            r_done      <= 1'b1;
                            r_cache_hit <= 1'b1;
                            r_hit_cnt   <= r_hit_cnt + 16'd1;
                            if (bus.Rd) begin
                                r_dout <= w_mem_q;
                            end
                        end else begin
                            r_state <= S_MISS_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_MISS_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                        r_done  <= 1'b1;
                        if (r_is_rd) begin
                            r_dout <= r_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DataOut  = r_dout;
    assign bus.Done     = r_done;
    assign bus.Stall    = r_stall;
    assign bus.CacheHit = r_cache_hit;
    assign bus.Err      = r_err;
    assign bus.ReqCount = r_req_cnt;
    assign bus.HitCount = r_hit_cnt;

endmodule

// File: doc/mem_resp_model.md
Name: mem_resp_model

Overview:
- Behavioural responder for the Addr/DataIn/Rd/Wr to DataOut/Done/Stall/CacheHit memory-system interface.
- Stands in for the real cache-plus-memory hierarchy, so that request generators and pipeline fetch/memory stages can be exercised against known, bounded timing.
- Keeps a direct-mapped tag array, so hits respond in 1 cycle and misses respond in a fixed, programmable number of cycles.
- Keeps a zero-initialised word memory, so read data is exact.

Parameters:
- MISS_LAT, 8: cycles from request acceptance to Done on a miss. Legal range is 3..20.
- TAG_W, 5: tag width, taken from Addr[15:11].
- IDX_W, 8: index width, taken from Addr[10:3]. There are 256 lines of 4 words each.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- Addr, input, 16: byte address. Addr[0] is ignored; the word address is Addr[15:1].
- DataIn, input, 16: write data.
- Rd, input, 1: read request.
- Wr, input, 1: write request.
- DataOut, output, 16: read data. Valid while Done=1 for a read.
- Done, output, 1: one-cycle response strobe.
- Stall, output, 1: high while the block is busy. New requests are ignored while Stall=1.
- CacheHit, output, 1: qualifies Done. 1 means the response took the hit path.
- Err, output, 1: sticky error flag. Set when Rd and Wr are both high in IDLE.
- ReqCount, output, 16: number of accepted requests. Wraps.
- HitCount, output, 16: number of responses with CacheHit=1. Wraps.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - DataOut, Done, Stall, CacheHit, Err, ReqCount, HitCount all go to 0.
  - All tag valid bits are cleared.
  - Word memory (32768 x 16) is zero at time 0 and is NOT cleared by rst_n.
  - Reset mid-request drops the request; no Done is produced.
- States:
  - IDLE
  - MISS_WAIT (counter cnt)
  - RESP
- IDLE, Rd^Wr=1 (acceptance):
  - Latch Addr, Rd/Wr and the hit decision.
  - Hit = valid[idx] && tag[idx]==Addr[15:11].
  - Write: mem[Addr[15:1]] <= DataIn at this edge.
  - Read: latch mem[Addr[15:1]] into the pending data register.
  - Allocate on every access, read or write: valid[idx]<=1, tag[idx]<=Addr[15:11].
  - ReqCount increments.
  - Hit: next state RESP.
  - Miss: next state MISS_WAIT with cnt=MISS_LAT-2.
- IDLE, Rd=Wr=1: not accepted. Err is set; nothing else changes.
- IDLE, Rd=Wr=0: stay in IDLE.
- MISS_WAIT: cnt decrements each cycle. When cnt==0, next state is RESP.
- RESP:
  - Done=1 for exactly one cycle.
  - CacheHit = latched hit.
  - DataOut = latched read data for a read. For a write, DataOut keeps its previous value.
  - HitCount increments if hit.
  - Next state IDLE.
- Timing:
  - Done occurs 1 cycle after acceptance on a hit.
  - Done occurs MISS_LAT cycles after acceptance on a miss.
  - Stall = (state != IDLE). Stall is therefore low in the cycle following RESP, and a new request can be accepted then.
- Outputs:
  - Done and CacheHit are registered (flop outputs).
  - DataOut holds until the next read response.
  - Inputs are ignored in every state other than IDLE.
- Back-to-back data coherence: a read following a write to the same word returns the written data (memory is updated at acceptance).
- Same index, different tag: the miss evicts the old line. There is no dirty/writeback timing; data always lives in the word memory.

Test Plan:
- Reset, then Rd Addr=0x6000:
  - Done at acceptance+8, CacheHit=0, DataOut=0x0000.
  - Rd Addr=0x6002 next: Done at +1, CacheHit=1, DataOut=0x0000.
- Wr Addr=0x0012 DataIn=0xBEEF (miss, Done at +8, CacheHit=0), then Rd 0x0012: Done at +1, CacheHit=1, DataOut=0xBEEF.
- Conflict on index 1:
  - Rd 0x0808 (tag 1) -> miss.
  - Rd 0x1008 (tag 2) -> miss.
  - Rd 0x0808 -> miss again.
  - HitCount=0, ReqCount=3.
- Rd=Wr=1 at Addr=0x0100:
  - Err=1 and stays 1.
  - No Done, Stall stays 0, ReqCount unchanged.
- Rd 0x2000, then rst_n pulsed low at acceptance+3:
  - Outputs are 0 immediately and no Done follows.
  - Rd 0x2000 after reset misses again (valid bits cleared).
- MISS_LAT=3 and MISS_LAT=20 builds: miss Done exactly 3 and 20 cycles after acceptance; Addr changes while Stall=1 are ignored.
